deparser_phv_to_pkt: RTL and testbench



---
 rtl/deparser_phv_to_pkt.sv | 253 +++++++++++++++++++++++++
 tb/tb_deparser_phv_to_pkt.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deparser_phv_to_pkt.sv
// Deparser: overwrites the leading beats of each buffered packet with the
// matching PHV slice group and streams the rebuilt packet out.

module deparser_phv_to_pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = i_pop && !o_empty;
        // a full FIFO still takes a write when the same cycle frees a slot
        do_push  = i_push && (!full || do_pop);
        o_drop   = i_push && !do_push;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        o_data   = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// state      | meaning
// IDLE       | wait for a packet beat and a slice to both be buffered
// LOAD       | pop a slice; non-START slices are discarded here
// MERGE      | emit beats with data taken from the current slice
// LOAD_NEXT  | pop the next slice of the group, then resume MERGE
// PASS       | slice group exhausted; emit remaining beats unchanged
// DRAIN      | packet ended early; discard slices through the TAIL slice
module deparser_phv_to_pkt #(
    parameter int HEAD_WIDTH     = 1024,
    parameter int TAG_WIDTH      = 8,
    parameter int TAG_START_BIT  = 0,
    parameter int TAG_TAIL_BIT   = 1,
    parameter int TAG_VALID_BIT  = 3,
    parameter int PKT_FIFO_DEPTH = 512,
    parameter int PHV_FIFO_DEPTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_pkt_valid,
    input  logic [133:0]                    i_pkt,
    input  logic                            i_phv_valid,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
    output logic                            o_pkt_valid,
    output logic [133:0]                    o_pkt,
    output logic                            o_err_ovf,
    output logic [31:0]                     o_pkt_cnt
);
    localparam int PKT_NUM = HEAD_WIDTH / 128;
    localparam int JW      = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
    localparam int SW      = HEAD_WIDTH + 2;
    localparam logic [JW-1:0] J_LAST = JW'(PKT_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_LOAD_NEXT,
        ST_PASS,
        ST_DRAIN
    } state_t;

    state_t                    state_q, state_d;
    logic [JW-1:0]             j_q, j_d;
    logic [PKT_NUM-1:0][127:0] slice_q, slice_d;
    logic                      tail_q, tail_d;
    logic                      valid_q, valid_d;
    logic [133:0]              pkt_q, pkt_d;
    logic                      ovf_q, ovf_d;
    logic [31:0]               cnt_q, cnt_d;

    logic [133:0]              pkt_rdata;
    logic                      pkt_empty;
    logic                      pkt_drop;
    logic                      pkt_pop;
    logic                      pkt_last;
    logic [SW-1:0]             phv_wdata;
    logic [SW-1:0]             phv_rdata;
    logic                      phv_push;
    logic                      phv_empty;
    logic                      phv_drop;
    logic                      phv_pop;
    logic                      phv_start;
    logic                      phv_tail;
    logic                      unused_tag;

    // only the START/TAIL flags travel with the slice data
    assign phv_push   = i_phv_valid && i_phv[HEAD_WIDTH+TAG_VALID_BIT];
    assign phv_wdata  = {i_phv[HEAD_WIDTH+TAG_START_BIT],
                         i_phv[HEAD_WIDTH+TAG_TAIL_BIT],
                         i_phv[HEAD_WIDTH-1:0]};
    assign unused_tag = ^i_phv[HEAD_WIDTH +: TAG_WIDTH];

    deparser_phv_to_pkt_fifo #(
        .WIDTH (134),
        .DEPTH (PKT_FIFO_DEPTH)
    ) u_pkt_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_pkt_valid),
        .i_data  (i_pkt),
        .i_pop   (pkt_pop),
        .o_data  (pkt_rdata),
        .o_empty (pkt_empty),
        .o_drop  (pkt_drop)
    );

    deparser_phv_to_pkt_fifo #(
        .WIDTH (SW),
        .DEPTH (PHV_FIFO_DEPTH)
    ) u_phv_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (phv_push),
        .i_data  (phv_wdata),
        .i_pop   (phv_pop),
        .o_data  (phv_rdata),
        .o_empty (phv_empty),
        .o_drop  (phv_drop)
    );

    assign pkt_last  = (pkt_rdata[133:132] == 2'b10);
    assign phv_start = phv_rdata[HEAD_WIDTH+1];
    assign phv_tail  = phv_rdata[HEAD_WIDTH];

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        slice_d = slice_q;
        tail_d  = tail_q;
        valid_d = 1'b0;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | pkt_drop | phv_drop;
        pkt_pop = 1'b0;
        phv_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!pkt_empty && !phv_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_LOAD_NEXT: begin
                if (!phv_empty) begin
                    phv_pop = 1'b1;
                    slice_d = phv_rdata[HEAD_WIDTH-1:0];
                    tail_d  = phv_tail;
                    j_d     = '0;
                    if (phv_start || state_q == ST_LOAD_NEXT) begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_MERGE: begin
                if (!pkt_empty) begin
                    pkt_pop = 1'b1;
                    valid_d = 1'b1;
                    // beat 0 of the slice sits in its most significant 128 bits
                    pkt_d   = {pkt_rdata[133:128], slice_q[J_LAST - j_q]};
                    j_d     = j_q + JW'(1);
                    if (pkt_last) begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = tail_q ? ST_IDLE : ST_DRAIN;
                    end else if (j_q == J_LAST) begin
                        state_d = tail_q ? ST_PASS : ST_LOAD_NEXT;
                    end
                end
            end
            ST_PASS: begin
                if (!pkt_empty) begin
                    pkt_pop = 1'b1;
                    valid_d = 1'b1;
                    pkt_d   = pkt_rdata;
                    if (pkt_last) begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!phv_empty) begin
                    phv_pop = 1'b1;
                    if (phv_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            slice_q <= '0;
            tail_q  <= 1'b0;
            valid_q <= 1'b0;
            pkt_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            slice_q <= slice_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pkt_valid = valid_q;
    assign o_pkt       = pkt_q;
    assign o_err_ovf   = ovf_q;
    assign o_pkt_cnt   = cnt_q;
endmodule

// File: tb/tb_deparser_phv_to_pkt.sv
// Directed bench for deparser_phv_to_pkt: merge, multi-slice, pass-through,
// drain, full-FIFO boundary, overflow and reset behaviour.
module tb_deparser_phv_to_pkt;
    localparam int HW = 1024;
    localparam int PW = HW + 8;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic           i_pkt_valid;
    logic [133:0]   i_pkt;
    logic           i_phv_valid;
    logic [PW-1:0]  i_phv;
    logic           o_pkt_valid;
    logic [133:0]   o_pkt;
    logic           o_err_ovf;
    logic [31:0]    o_pkt_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [133:0]  out_q[$];
    int            out_cyc[$];
    logic [133:0]  pin_q[$];
    logic [PW-1:0] sin_q[$];

    deparser_phv_to_pkt dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pkt_valid (i_pkt_valid),
        .i_pkt       (i_pkt),
        .i_phv_valid (i_phv_valid),
        .i_phv       (i_phv),
        .o_pkt_valid (o_pkt_valid),
        .o_pkt       (o_pkt),
        .o_err_ovf   (o_err_ovf),
        .o_pkt_cnt   (o_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc = cyc + 1;

    always @(negedge i_clk) begin
        if (o_pkt_valid === 1'b1) begin
            out_q.push_back(o_pkt);
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] pdata(input int p, input int k);
        return {64'hAAAA_AAAA_AAAA_AAAA, p[31:0], k[31:0]};
    endfunction

    function automatic logic [127:0] sdata(input int s, input int b);
        return {64'hBBBB_BBBB_BBBB_BBBB, s[31:0], b[31:0]};
    endfunction

    function automatic logic [1:0] hdr_of(input int k, input int nb);
        if (k == 0) return 2'b01;
        if (k == nb - 1) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [133:0] beat(input logic [1:0] hdr, input int p, input int k);
        return {hdr, 4'(p), pdata(p, k)};
    endfunction

    function automatic logic [PW-1:0] mk_slice(input int s, input logic [7:0] tag);
        logic [PW-1:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) v[HW-1-128*b -: 128] = sdata(s, b);
        v[HW +: 8] = tag;
        return v;
    endfunction

    task automatic add_pkt(input int p, input int nb);
        for (int k = 0; k < nb; k++) pin_q.push_back(beat(hdr_of(k, nb), p, k));
    endtask

    task automatic add_fill(input int p, input int nb);
        for (int k = 0; k < nb; k++) pin_q.push_back(beat((k == 0) ? 2'b01 : 2'b11, p, k));
    endtask

    // Streams queued beats and slices, one of each per cycle, in parallel.
    task automatic drive(output int first_edge);
        first_edge = -1;
        while (pin_q.size() > 0 || sin_q.size() > 0) begin
            if (pin_q.size() > 0) begin
                i_pkt_valid = 1'b1;
                i_pkt = pin_q.pop_front();
            end else begin
                i_pkt_valid = 1'b0;
            end
            if (sin_q.size() > 0) begin
                i_phv_valid = 1'b1;
                i_phv = sin_q.pop_front();
            end else begin
                i_phv_valid = 1'b0;
            end
            @(posedge i_clk); #1;
            if (first_edge < 0) first_edge = cyc;
        end
        i_pkt_valid = 1'b0;
        i_phv_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        int c;
        c = 0;
        while (out_q.size() < n && c < 80) begin
            @(posedge i_clk); #1;
            c++;
        end
        checks++;
        if (out_q.size() < n) begin
            failures++;
            $display("FAIL %s timeout: beats=%0d required=%0d", name, out_q.size(), n);
        end
        repeat (4) begin @(posedge i_clk); #1; end
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        #1;
        checks += 4;
        if (o_pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", o_pkt_valid); end
        if (o_pkt !== 134'd0) begin failures++; $display("FAIL reset_pkt: got %h required 0", o_pkt); end
        if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", o_err_ovf); end
        if (o_pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %0d required 0", o_pkt_cnt); end
        i_rst_n = 1'b1;
        repeat (3) begin @(posedge i_clk); #1; end
        checks++;
        if (out_q.size() != 0) begin failures++; $display("FAIL reset_idle_out: beats=%0d required 0", out_q.size()); end
    endtask

    task automatic test_single_slice();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_pkt(1, 4);
        sin_q.push_back(mk_slice(1, 8'h0B));
        drive(fe);
        wait_out(4, "single");
        checks++;
        if (out_q.size() != 4) begin failures++; $display("FAIL single_count: got %0d required 4", out_q.size()); end
        for (int k = 0; k < 4; k++) begin
            exp = {hdr_of(k, 4), 4'd1, sdata(1, k)};
            checks++;
            if (out_q[k] !== exp) begin failures++; $display("FAIL single_beat%0d: got %h required %h", k, out_q[k], exp); end
        end
        checks += 3;
        if (out_cyc[0] - fe != 3) begin failures++; $display("FAIL single_latency: got %0d required 3", out_cyc[0] - fe); end
        if (out_cyc[3] - out_cyc[0] != 3) begin failures++; $display("FAIL single_rate: got %0d required 3", out_cyc[3] - out_cyc[0]); end
        if (o_pkt_cnt !== 32'd1) begin failures++; $display("FAIL single_cnt: got %0d required 1", o_pkt_cnt); end
    endtask

    task automatic test_two_slices();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_pkt(2, 12);
        sin_q.push_back(mk_slice(2, 8'h09));
        sin_q.push_back(mk_slice(3, 8'h0A));
        drive(fe);
        wait_out(12, "two_slices");
        checks++;
        if (out_q.size() != 12) begin failures++; $display("FAIL two_count: got %0d required 12", out_q.size()); end
        for (int k = 0; k < 12; k++) begin
            exp = {hdr_of(k, 12), 4'd2, (k < 8) ? sdata(2, k) : sdata(3, k - 8)};
            checks++;
            if (out_q[k] !== exp) begin failures++; $display("FAIL two_beat%0d: got %h required %h", k, out_q[k], exp); end
        end
        checks += 4;
        if (out_cyc[7] - out_cyc[0] != 7) begin failures++; $display("FAIL two_first_run: got %0d required 7", out_cyc[7] - out_cyc[0]); end
        if (out_cyc[8] - out_cyc[7] != 2) begin failures++; $display("FAIL two_bubble: got %0d required 2", out_cyc[8] - out_cyc[7]); end
        if (out_cyc[11] - out_cyc[8] != 3) begin failures++; $display("FAIL two_second_run: got %0d required 3", out_cyc[11] - out_cyc[8]); end
        if (o_pkt_cnt !== 32'd2) begin failures++; $display("FAIL two_cnt: got %0d required 2", o_pkt_cnt); end
    endtask

    task automatic test_pass_through();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_pkt(3, 10);
        sin_q.push_back(mk_slice(4, 8'h0B));
        drive(fe);
        wait_out(10, "pass");
        checks++;
        if (out_q.size() != 10) begin failures++; $display("FAIL pass_count: got %0d required 10", out_q.size()); end
        for (int k = 0; k < 10; k++) begin
            exp = (k < 8) ? {hdr_of(k, 10), 4'd3, sdata(4, k)} : beat(hdr_of(k, 10), 3, k);
            checks++;
            if (out_q[k] !== exp) begin failures++; $display("FAIL pass_beat%0d: got %h required %h", k, out_q[k], exp); end
        end
        checks += 2;
        if (out_cyc[9] - out_cyc[0] != 9) begin failures++; $display("FAIL pass_rate: got %0d required 9", out_cyc[9] - out_cyc[0]); end
        if (o_pkt_cnt !== 32'd3) begin failures++; $display("FAIL pass_cnt: got %0d required 3", o_pkt_cnt); end
    endtask

    // Short packet leaves a slice to drain; a stray non-START slice and a
    // slice with the valid tag bit clear must not pair with the next packet.
    task automatic test_drain();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_pkt(4, 3);
        add_pkt(5, 2);
        sin_q.push_back(mk_slice(5, 8'h09));
        sin_q.push_back(mk_slice(6, 8'h0A));
        sin_q.push_back(mk_slice(7, 8'h08));
        sin_q.push_back(mk_slice(8, 8'h03));
        sin_q.push_back(mk_slice(9, 8'h0B));
        drive(fe);
        wait_out(5, "drain");
        checks++;
        if (out_q.size() != 5) begin failures++; $display("FAIL drain_count: got %0d required 5", out_q.size()); end
        for (int k = 0; k < 5; k++) begin
            exp = (k < 3) ? {hdr_of(k, 3), 4'd4, sdata(5, k)} : {hdr_of(k - 3, 2), 4'd5, sdata(9, k - 3)};
            checks++;
            if (out_q[k] !== exp) begin failures++; $display("FAIL drain_beat%0d: got %h required %h", k, out_q[k], exp); end
        end
        checks++;
        if (o_pkt_cnt !== 32'd5) begin failures++; $display("FAIL drain_cnt: got %0d required 5", o_pkt_cnt); end
    endtask

    // Full packet FIFO written in the same cycle MERGE pops it: no overflow.
    task automatic test_full_simultaneous();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_fill(6, 512);
        drive(fe);
        checks++;
        if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL simul_fill_ovf: got %b required 0", o_err_ovf); end
        i_phv_valid = 1'b1;
        i_phv = mk_slice(11, 8'h0B);
        @(posedge i_clk); #1;
        i_phv_valid = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_pkt_valid = 1'b1;
        i_pkt = beat(2'b11, 6, 512);
        @(posedge i_clk); #1;
        i_pkt_valid = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        exp = {2'b01, 4'd6, sdata(11, 0)};
        checks += 2;
        if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL simul_ovf: got %b required 0", o_err_ovf); end
        if (out_q[0] !== exp) begin failures++; $display("FAIL simul_first_beat: got %h required %h", out_q[0], exp); end
        pulse_reset();
        checks += 3;
        if (o_pkt_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b required 0", o_pkt_valid); end
        if (o_pkt !== 134'd0) begin failures++; $display("FAIL midreset_pkt: got %h required 0", o_pkt); end
        if (o_pkt_cnt !== 32'd0) begin failures++; $display("FAIL midreset_cnt: got %0d required 0", o_pkt_cnt); end
        out_q.delete(); out_cyc.delete();
        repeat (3) begin @(posedge i_clk); #1; end
        checks++;
        if (out_q.size() != 0) begin failures++; $display("FAIL midreset_out: beats=%0d required 0", out_q.size()); end
    endtask

    task automatic test_overflow();
        int fe;
        logic [133:0] exp;
        out_q.delete(); out_cyc.delete();
        add_fill(7, 512);
        drive(fe);
        checks++;
        if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_at_512: got %b required 0", o_err_ovf); end
        pin_q.push_back(beat(2'b11, 7, 512));
        drive(fe);
        checks++;
        if (o_err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1", o_err_ovf); end
        repeat (5) begin @(posedge i_clk); #1; end
        checks++;
        if (o_err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", o_err_ovf); end
        pulse_reset();
        checks += 4;
        if (o_pkt_valid !== 1'b0) begin failures++; $display("FAIL ovfreset_valid: got %b required 0", o_pkt_valid); end
        if (o_pkt !== 134'd0) begin failures++; $display("FAIL ovfreset_pkt: got %h required 0", o_pkt); end
        if (o_err_ovf !== 1'b0) begin failures++; $display("FAIL ovfreset_ovf: got %b required 0", o_err_ovf); end
        if (o_pkt_cnt !== 32'd0) begin failures++; $display("FAIL ovfreset_cnt: got %0d required 0", o_pkt_cnt); end
        // stale beats left in the FIFO would show up here with sideband 7
        out_q.delete(); out_cyc.delete();
        add_pkt(8, 2);
        sin_q.push_back(mk_slice(10, 8'h0B));
        drive(fe);
        wait_out(2, "post_reset");
        for (int k = 0; k < 2; k++) begin
            exp = {hdr_of(k, 2), 4'd8, sdata(10, k)};
            checks++;
            if (out_q[k] !== exp) begin failures++; $display("FAIL postreset_beat%0d: got %h required %h", k, out_q[k], exp); end
        end
        checks += 2;
        if (out_q.size() != 2) begin failures++; $display("FAIL postreset_count: got %0d required 2", out_q.size()); end
        if (o_pkt_cnt !== 32'd1) begin failures++; $display("FAIL postreset_cnt: got %0d required 1", o_pkt_cnt); end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_pkt_valid = 1'b0;
        i_pkt       = '0;
        i_phv_valid = 1'b0;
        i_phv       = '0;
        test_reset();
        test_single_slice();
        test_two_slices();
        test_pass_through();
        test_drain();
        test_full_simultaneous();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
